ee354_2048_move_sequencer: RTL

//  Top-level sequencer for the 2048 board datapath. Converts direction buttons into one move command at a time,

---
 rtl/ee354_2048_move_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ee354_2048_move_sequencer.sv
// ee354_2048_move_sequencer
//   Top-level sequencer for the 2048 board datapath. It turns direction button
//   edges into one move command at a time, handshakes with the board engine,
//   spawns a tile in a pseudo-random empty cell after each effective move, and
//   evaluates win/lose.
// Ports
//   Clk, Reset                 clock (posedge), asynchronous active-low reset
//   btn_up/down/left/right     debounced button levels
//   new_game                   1-cycle restart pulse, honoured in every state
//   board_clr                  1-cycle pulse: datapath zeroes all cells
//   move_req/move_dir/move_ack/board_changed   move handshake
//   spawn_req/spawn_idx/spawn_four/spawn_ack   spawn handshake
//   empty_mask, has_2048, can_merge            live board status
//   busy, q_win, q_lose, timeout_err, move_count  status outputs (registered)
module ee354_2048_move_sequencer #(
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned ACK_TIMEOUT = 1023,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             new_game,
    output logic             board_clr,
    output logic             move_req,
    output logic [1:0]       move_dir,
    input  logic             move_ack,
    input  logic             board_changed,
    output logic             spawn_req,
    output logic [3:0]       spawn_idx,
    output logic             spawn_four,
    input  logic             spawn_ack,
    input  logic [15:0]      empty_mask,
    input  logic             has_2048,
    input  logic             can_merge,
    output logic             busy,
    output logic             q_win,
    output logic             q_lose,
    output logic             timeout_err,
    output logic [CNT_W-1:0] move_count
);

    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [3:0] {
        S_INIT, S_SPAWN0, S_SPAWN1, S_IDLE, S_MOVE, S_SPAWN, S_CHECK, S_WIN, S_LOSE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [3:0]         btn_hist_q, btn_now, btn_rise;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               board_clr_q, board_clr_d;
    logic               move_req_q, move_req_d;
    logic [1:0]         move_dir_q, move_dir_d;
    logic               spawn_req_q, spawn_req_d;
    logic [3:0]         spawn_idx_q, spawn_idx_d;
    logic               spawn_four_q, spawn_four_d;
    logic               busy_q, busy_d;
    logic               q_win_q, q_win_d;
    logic               q_lose_q, q_lose_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   move_count_q, move_count_d;
    logic               pick_found;
    logic [3:0]         pick_idx, cand;
    logic               tmo_hit;
    state_t             spawn_next;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        board_clr_d   = 1'b0;
        move_req_d    = move_req_q;
        move_dir_d    = move_dir_q;
        spawn_req_d   = spawn_req_q;
        spawn_idx_d   = spawn_idx_q;
        spawn_four_d  = spawn_four_q;
        timeout_err_d = 1'b0;
        move_count_d  = move_count_q;
        tmo_d         = tmo_q;

        btn_now  = {btn_up, btn_down, btn_left, btn_right};
        btn_rise = btn_now & ~btn_hist_q;
        lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        tmo_hit  = (tmo_q == TMO_W'(1));

        // First empty cell scanning upward from lfsr[3:0], wrapping 15 -> 0
        pick_found = 1'b0;
        pick_idx   = 4'h0;
        cand       = 4'h0;
        for (int i = 0; i < 16; i++) begin
            cand = lfsr_q[3:0] + 4'(i);
            if (!pick_found && empty_mask[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end

        case (state_q)
            S_SPAWN0: spawn_next = S_SPAWN1;
            S_SPAWN1: spawn_next = S_IDLE;
            default:  spawn_next = S_CHECK;
        endcase

        case (state_q)
            // Two-cycle INIT so the clear has landed before the first spawn samples empty_mask
            S_INIT: begin
                move_count_d = '0;
                if (!board_clr_q) board_clr_d = 1'b1;
                else              state_d     = S_SPAWN0;
            end
            // spawn_req low marks the entry cycle of a spawn state
            S_SPAWN0, S_SPAWN1, S_SPAWN: begin
                if (!spawn_req_q) begin
                    if (pick_found) begin
                        spawn_req_d  = 1'b1;
                        spawn_idx_d  = pick_idx;
                        spawn_four_d = (lfsr_q[7:4] == 4'h0);
                        tmo_d        = TMO_W'(ACK_TIMEOUT);
                    end else begin
                        state_d = spawn_next;
                    end
                end else if (spawn_ack) begin
                    spawn_req_d = 1'b0;
                    state_d     = spawn_next;
                end else if (tmo_hit) begin
                    spawn_req_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            S_IDLE: begin
                if (|btn_rise) begin
                    move_req_d = 1'b1;
                    tmo_d      = TMO_W'(ACK_TIMEOUT);
                    state_d    = S_MOVE;
                    if      (btn_rise[3]) move_dir_d = 2'b00;
                    else if (btn_rise[2]) move_dir_d = 2'b01;
                    else if (btn_rise[1]) move_dir_d = 2'b10;
                    else                  move_dir_d = 2'b11;
                end
            end
            S_MOVE: begin
                if (move_ack) begin
                    move_req_d = 1'b0;
                    if (board_changed) begin
                        if (move_count_q != {CNT_W{1'b1}})
                            move_count_d = move_count_q + CNT_W'(1);
                        state_d = S_SPAWN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_hit) begin
                    move_req_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            S_CHECK: begin
                if (has_2048)                             state_d = S_WIN;
                else if ((empty_mask == 16'h0) && !can_merge) state_d = S_LOSE;
                else                                      state_d = S_IDLE;
            end
            S_WIN, S_LOSE: state_d = state_q;
            default:       state_d = S_INIT;
        endcase

        // Restart overrides everything, abandoning any open handshake
        if (new_game) begin
            state_d       = S_INIT;
            board_clr_d   = 1'b0;
            move_req_d    = 1'b0;
            spawn_req_d   = 1'b0;
            timeout_err_d = 1'b0;
            move_count_d  = '0;
        end

        busy_d   = !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
        q_win_d  = (state_d == S_WIN);
        q_lose_d = (state_d == S_LOSE);
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_INIT;
            lfsr_q        <= LFSR_SEED;
            btn_hist_q    <= 4'h0;
            tmo_q         <= '0;
            board_clr_q   <= 1'b0;
            move_req_q    <= 1'b0;
            move_dir_q    <= 2'b00;
            spawn_req_q   <= 1'b0;
            spawn_idx_q   <= 4'h0;
            spawn_four_q  <= 1'b0;
            busy_q        <= 1'b0;
            q_win_q       <= 1'b0;
            q_lose_q      <= 1'b0;
            timeout_err_q <= 1'b0;
            move_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            btn_hist_q    <= btn_now;
            tmo_q         <= tmo_d;
            board_clr_q   <= board_clr_d;
            move_req_q    <= move_req_d;
            move_dir_q    <= move_dir_d;
            spawn_req_q   <= spawn_req_d;
            spawn_idx_q   <= spawn_idx_d;
            spawn_four_q  <= spawn_four_d;
            busy_q        <= busy_d;
            q_win_q       <= q_win_d;
            q_lose_q      <= q_lose_d;
            timeout_err_q <= timeout_err_d;
            move_count_q  <= move_count_d;
        end
    end

    assign board_clr   = board_clr_q;
    assign move_req    = move_req_q;
    assign move_dir    = move_dir_q;
    assign spawn_req   = spawn_req_q;
    assign spawn_idx   = spawn_idx_q;
    assign spawn_four  = spawn_four_q;
    assign busy        = busy_q;
    assign q_win       = q_win_q;
    assign q_lose      = q_lose_q;
    assign timeout_err = timeout_err_q;
    assign move_count  = move_count_q;

endmodule
